// File: rtl/aes192_key_sched_seq.sv
// Sequential AES-192 key expansion: one 6-word schedule step per cycle into a 52-word store,
// then the 13 round keys are streamed forward (encrypt) or reverse (decrypt).
module aes192_key_sched_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic [191:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic         dir,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         rk_last,
  output logic         busy
);
  localparam int unsigned NR    = 12;
  localparam int unsigned NK    = 6;
  localparam int unsigned NW    = 4 * (NR + 1);
  localparam int unsigned STEPS = (NW + NK - 1) / NK - 1;
  localparam int unsigned IW    = $clog2(NW + NK);

  typedef enum logic [1:0] {IDLE, EXPAND, STREAM} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse as x^254 (zero maps to zero), then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      inv = gf_mul(inv, inv);
      inv = gf_mul(inv, x);
    end
    inv = gf_mul(inv, inv);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_t          state, state_n;
  logic [3:0]      step, step_n;
  logic            dir_q, dir_n;
  logic            key_ready_n, busy_n, rk_valid_n, rk_last_n;
  logic [127:0]    rk_out_n;
  logic [3:0]      rk_idx_n;
  logic [IW-1:0]   ra;

  logic [31:0]     win   [NK];
  logic [31:0]     nw    [NK];
  logic [31:0]     store [NW];
  logic [31:0]     t;
  logic [7:0]      rc;
  logic [IW-1:0]   base;

  // One key-schedule step from the last six words held in win
  always_comb begin
    rc    = 8'h01 << (step - 4'd1);
    t     = sub_word({win[NK-1][23:0], win[NK-1][31:24]}) ^ {rc, 24'h0};
    nw[0] = win[0] ^ t;
    for (int k = 1; k < NK; k++) nw[k] = win[k] ^ nw[k-1];
    base  = IW'(step) * IW'(NK);
  end

  always_comb begin
    state_n     = state;
    step_n      = step;
    dir_n       = dir_q;
    key_ready_n = key_ready;
    busy_n      = busy;
    rk_valid_n  = rk_valid;
    rk_out_n    = rk_out;
    rk_idx_n    = rk_idx;
    rk_last_n   = rk_last;
    ra          = '0;
    case (state)
      IDLE: begin
        if (key_valid && key_ready) begin
          state_n     = EXPAND;
          step_n      = 4'd1;
          dir_n       = dir;
          key_ready_n = 1'b0;
          busy_n      = 1'b1;
        end
      end
      EXPAND: begin
        if (step == 4'(STEPS)) begin
          state_n    = STREAM;
          step_n     = '0;
          rk_valid_n = 1'b1;
          // Reverse order starts on the words being written this very edge
          if (dir_q) begin
            rk_idx_n = 4'(NR);
            rk_out_n = {nw[0], nw[1], nw[2], nw[3]};
          end else begin
            rk_idx_n = '0;
            rk_out_n = {store[0], store[1], store[2], store[3]};
          end
        end else begin
          step_n = step + 4'd1;
        end
      end
      STREAM: begin
        if (rk_valid && rk_ready) begin
          if (rk_last) begin
            state_n     = IDLE;
            rk_valid_n  = 1'b0;
            rk_out_n    = '0;
            rk_idx_n    = '0;
            rk_last_n   = 1'b0;
            busy_n      = 1'b0;
            key_ready_n = 1'b1;
          end else begin
            rk_idx_n  = dir_q ? rk_idx - 4'd1 : rk_idx + 4'd1;
            ra        = IW'({rk_idx_n, 2'b00});
            rk_out_n  = {store[ra], store[ra + IW'(1)], store[ra + IW'(2)], store[ra + IW'(3)]};
            rk_last_n = dir_q ? (rk_idx_n == 4'd0) : (rk_idx_n == 4'(NR));
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      step      <= '0;
      dir_q     <= 1'b0;
      key_ready <= 1'b1;
      busy      <= 1'b0;
      rk_valid  <= 1'b0;
      rk_out    <= '0;
      rk_idx    <= '0;
      rk_last   <= 1'b0;
    end else begin
      state     <= state_n;
      step      <= step_n;
      dir_q     <= dir_n;
      key_ready <= key_ready_n;
      busy      <= busy_n;
      rk_valid  <= rk_valid_n;
      rk_out    <= rk_out_n;
      rk_idx    <= rk_idx_n;
      rk_last   <= rk_last_n;
    end
  end

  // Word store and step window are never cleared; stale words are always overwritten first
  always_ff @(posedge clk) begin
    if (state == IDLE && key_valid && key_ready) begin
      for (int k = 0; k < NK; k++) begin
        win[k]   <= key_in[32*(NK-1-k) +: 32];
        store[k] <= key_in[32*(NK-1-k) +: 32];
      end
    end else if (state == EXPAND) begin
      for (int k = 0; k < NK; k++) begin
        win[k] <= nw[k];
        if (int'(base) + k < int'(NW)) store[base + IW'(k)] <= nw[k];
      end
    end
  end

endmodule

// File: tb/tb_aes192_key_sched_seq.sv
// Bench for aes192_key_sched_seq: random keys, directions and back-pressure against a
// word-by-word key expansion model, plus an AES-192 encryption built from the streamed keys.
module tb_aes192_key_sched_seq;
  logic         clk = 1'b0;
  logic         rst;
  logic [191:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         dir;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         rk_ready;
  logic         rk_last;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sb     [256];
  logic [127:0] rk_exp [13];
  logic [127:0] got_rk [13];

  localparam logic [191:0] FIPS_KEY = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [191:0] SEQ_KEY  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;

  aes192_key_sched_seq dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .dir(dir), .rk_out(rk_out), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_last(rk_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Carry-less product reduced modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  task automatic model_expand(input logic [191:0] k);
    logic [31:0] w [52];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 6; i++) w[i] = k[191-32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      tmp = w[i-1];
      if (i % 6 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-6] ^ tmp;
    end
    for (int j = 0; j < 13; j++) rk_exp[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] ct;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ got_rk[0][127-8*i -: 8];
    for (int r = 1; r <= 12; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[rr+4*c] = t[rr + 4*((c+rr)%4)];
      if (r != 12) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
          s[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ got_rk[r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    return ct;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_key_ready"}, 128'(key_ready), 128'd1);
    check({tag, "_rk_valid"},  128'(rk_valid),  128'd0);
    check({tag, "_busy"},      128'(busy),      128'd0);
    check({tag, "_rk_out"},    rk_out,          128'd0);
    check({tag, "_rk_idx"},    128'(rk_idx),    128'd0);
    check({tag, "_rk_last"},   128'(rk_last),   128'd0);
  endtask

  // Called at a negedge with the block idle; returns at the first negedge after acceptance
  task automatic accept_key(input logic [191:0] k, input logic d,
                            input logic [191:0] after, input logic keep);
    key_in    = k;
    dir       = d;
    key_valid = 1'b1;
    check("key_ready_idle", 128'(key_ready), 128'd1);
    @(negedge clk);
    key_in    = after;
    dir       = ~d;
    key_valid = keep;
  endtask

  task automatic wait_latency();
    int lat;
    lat = 0;
    check("busy_expand", 128'(busy), 128'd1);
    check("key_ready_expand", 128'(key_ready), 128'd0);
    while (!rk_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 128'(lat), 128'd8);
  endtask

  task automatic stream(input logic d, input logic rnd, input logic stall, input int abort_idx);
    int           beats, cyc, stall_cnt, e;
    logic         r, prev_ready, aborted;
    logic [127:0] p_out;
    logic [3:0]   p_idx;
    logic         p_last;
    beats = 0; cyc = 0; stall_cnt = 0; prev_ready = 1'b1; aborted = 1'b0;
    p_out = '0; p_idx = '0; p_last = 1'b0;
    while (beats < 13 && cyc < 400) begin
      if (abort_idx >= 0 && rk_valid && rk_idx == 4'(abort_idx)) begin
        rk_ready = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset("rst_stream");
        aborted = 1'b1;
        break;
      end
      if (!prev_ready) begin
        check("stall_rk_out", rk_out, p_out);
        check("stall_rk_idx", 128'(rk_idx), 128'(p_idx));
        check("stall_rk_last", 128'(rk_last), 128'(p_last));
      end
      check("rk_valid_stream", 128'(rk_valid), 128'd1);
      check("key_ready_stream", 128'(key_ready), 128'd0);
      r = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (stall && rk_idx == 4'd6 && stall_cnt < 5) begin
        r = 1'b0;
        stall_cnt++;
      end
      rk_ready = r;
      if (r && rk_valid) begin
        e = d ? 12 - beats : beats;
        check("rk_idx", 128'(rk_idx), 128'(e));
        check("rk_out", rk_out, rk_exp[e]);
        check("rk_last", 128'(rk_last), 128'(beats == 12));
        got_rk[rk_idx % 13] = rk_out;
        beats++;
      end
      prev_ready = r; p_out = rk_out; p_idx = rk_idx; p_last = rk_last;
      @(negedge clk);
      cyc++;
    end
    rk_ready = 1'b1;
    if (abort_idx >= 0) begin
      check("abort_seen", 128'(aborted), 128'd1);
    end else begin
      check("stream_beats", 128'(beats), 128'd13);
      check_reset("post_stream");
    end
  endtask

  initial begin
    logic [191:0] k, kb;
    logic         d;
    rst = 1'b1; key_in = '0; key_valid = 1'b0; dir = 1'b0; rk_ready = 1'b1;
    build_sbox();
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Known-answer key, forward then reverse
    model_expand(FIPS_KEY);
    accept_key(FIPS_KEY, 1'b0, {6{$urandom()}}, 1'b0);
    wait_latency();
    stream(1'b0, 1'b0, 1'b0, -1);
    check("fips_idx0",  got_rk[0],  128'h8e73b0f7da0e6452c810f32b809079e5);
    check("fips_idx1",  got_rk[1],  128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    check("fips_idx2",  got_rk[2],  128'hec12068e6c827f6b0e7a95b95c56fec2);
    check("fips_idx12", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);
    accept_key(FIPS_KEY, 1'b1, {6{$urandom()}}, 1'b0);
    wait_latency();
    stream(1'b1, 1'b0, 1'b0, -1);
    check("rev_idx12", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);
    check("rev_idx0",  got_rk[0],  128'h8e73b0f7da0e6452c810f32b809079e5);

    // Random back-pressure with a 5-cycle stall at idx 6
    accept_key(FIPS_KEY, 1'b0, {6{$urandom()}}, 1'b0);
    wait_latency();
    stream(1'b0, 1'b1, 1'b1, -1);

    // Second key held valid through expansion and streaming
    kb = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    accept_key(FIPS_KEY, 1'b0, kb, 1'b1);
    dir = 1'b0;
    wait_latency();
    stream(1'b0, 1'b1, 1'b0, -1);
    model_expand(kb);
    @(negedge clk);
    key_valid = 1'b0;
    wait_latency();
    stream(1'b0, 1'b0, 1'b0, -1);

    // Asynchronous reset during EXPAND and during STREAM
    accept_key(FIPS_KEY, 1'b0, {6{$urandom()}}, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset("rst_expand");
    @(negedge clk);
    rst = 1'b0;
    model_expand(FIPS_KEY);
    accept_key(FIPS_KEY, 1'b0, {6{$urandom()}}, 1'b0);
    wait_latency();
    stream(1'b0, 1'b0, 1'b0, 7);
    @(negedge clk);
    rst = 1'b0;

    // Fresh key after reset, then encrypt with the streamed keys
    model_expand(SEQ_KEY);
    accept_key(SEQ_KEY, 1'b0, {6{$urandom()}}, 1'b0);
    wait_latency();
    stream(1'b0, 1'b0, 1'b0, -1);
    check("seq_idx0", got_rk[0], 128'h000102030405060708090a0b0c0d0e0f);
    check("aes192_ct", aes_enc(128'h00112233445566778899aabbccddeeff),
          128'hdda97ca4864cdfe06eaf70a0ec0d7191);

    // Random keys, directions and back-pressure
    for (int n = 0; n < 6; n++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      d = 1'($urandom_range(0, 1));
      model_expand(k);
      accept_key(k, d, {6{$urandom()}}, 1'b0);
      wait_latency();
      stream(d, 1'b1, 1'b0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
